// File: rtl/cache_pkg.sv
// Shared types and default geometry for the set-associative cache controller.
package cache_pkg;

    localparam int unsigned DEF_TAG_WIDTH    = 18;
    localparam int unsigned DEF_SET_WIDTH    = 8;
    localparam int unsigned DEF_OFFSET_WIDTH = 6;
    localparam int unsigned DEF_WAYS         = 4;

    typedef enum logic [2:0] {
        IDLE,
        WRITE_BACK,
        READ_MEM,
        WRITE_AROUND,
        DONE
    } cache_state_t;

    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0]    tag;
        logic [DEF_SET_WIDTH-1:0]    index;
        logic [DEF_OFFSET_WIDTH-3:0] word;
        logic [1:0]                  byte_sel;
    } addr_fields_t;

    // Split a 32-bit address into tag / index / word offset for the default geometry.
    function automatic addr_fields_t split_addr(input logic [31:0] addr);
        return addr_fields_t'(addr);
    endfunction

endpackage

// File: rtl/cache_beat_counter.sv
// Word counter for line bursts: synchronous clear beats increment.
module cache_beat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_controller_nway.sv
// N-way write-back cache controller: hit handling, write-back/refill bursts
// and optional write-around on write misses.
module cache_controller_nway
    import cache_pkg::*;
#(
    parameter int unsigned TAG_WIDTH      = DEF_TAG_WIDTH,
    parameter int unsigned SET_WIDTH      = DEF_SET_WIDTH,
    parameter int unsigned OFFSET_WIDTH   = DEF_OFFSET_WIDTH,
    parameter int unsigned WAYS           = DEF_WAYS,
    parameter bit          WRITE_ALLOCATE = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         write_en_i,
    input  logic [31:0]                  addr_i,
    input  logic [WAYS-1:0]              hit_way_i,
    input  logic [WAYS-1:0]              valid_i,
    input  logic [WAYS-1:0]              dirty_i,
    input  logic [WAYS*TAG_WIDTH-1:0]    tag_line_i,
    input  logic [$clog2(WAYS)-1:0]      victim_i,
    output logic                         stall_o,
    output logic [WAYS-1:0]              way_sel_o,
    output logic                         line_write_en_o,
    output logic                         update_en_o,
    output logic                         set_valid_o,
    output logic                         set_dirty_o,
    output logic [OFFSET_WIDTH-3:0]      offset_line_o,
    output logic                         mem_req_o,
    output logic                         mem_write_en_o,
    output logic [31:0]                  mem_addr_o,
    input  logic                         mem_ready_i
);

    localparam int unsigned CNT_W     = OFFSET_WIDTH - 2;
    localparam int unsigned LINE_SIZE = 2 ** CNT_W;
    localparam int unsigned VICT_W    = $clog2(WAYS);

    cache_state_t          state, state_next;
    logic [CNT_W-1:0]      count;
    logic [VICT_W-1:0]     vict_idx;
    logic [TAG_WIDTH-1:0]  vict_tag;
    logic                  hit, miss, in_burst, beat_inc, last_beat;
    logic [TAG_WIDTH-1:0]  addr_tag;
    logic [SET_WIDTH-1:0]  addr_index;

    assign addr_tag   = addr_i[31 -: TAG_WIDTH];
    assign addr_index = addr_i[OFFSET_WIDTH +: SET_WIDTH];
    assign hit        = en_i & (|hit_way_i);
    assign miss       = en_i & ~(|hit_way_i);
    assign in_burst   = (state == WRITE_BACK) || (state == READ_MEM);
    assign beat_inc   = in_burst && mem_ready_i;
    assign last_beat  = beat_inc && (count == CNT_W'(LINE_SIZE - 1));

    cache_beat_counter #(
        .WIDTH(CNT_W)
    ) u_beat_counter (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (last_beat),
        .inc   (beat_inc),
        .count (count)
    );

    // State register and victim latch, captured once per miss so the burst
    // is immune to later changes in the set array outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            vict_idx <= '0;
            vict_tag <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && miss) begin
                vict_idx <= victim_i;
                vict_tag <= tag_line_i[int'(victim_i) * TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next      = state;
        stall_o         = 1'b0;
        way_sel_o       = '0;
        line_write_en_o = 1'b0;
        update_en_o     = 1'b0;
        set_valid_o     = 1'b0;
        set_dirty_o     = 1'b0;
        offset_line_o   = '0;
        mem_req_o       = 1'b0;
        mem_write_en_o  = 1'b0;
        mem_addr_o      = '0;

        case (state)
            IDLE: begin
                stall_o = miss;
                if (hit) begin
                    way_sel_o       = hit_way_i;
                    update_en_o     = 1'b1;
                    line_write_en_o = write_en_i;
                    set_dirty_o     = write_en_i;
                    offset_line_o   = addr_i[OFFSET_WIDTH-1:2];
                end
                if (miss) begin
                    if (write_en_i && !WRITE_ALLOCATE) begin
                        state_next = WRITE_AROUND;
                    end else if (valid_i[victim_i] && dirty_i[victim_i]) begin
                        state_next = WRITE_BACK;
                    end else begin
                        state_next = READ_MEM;
                    end
                end
            end

            WRITE_BACK: begin
                stall_o        = 1'b1;
                mem_req_o      = 1'b1;
                mem_write_en_o = 1'b1;
                way_sel_o      = WAYS'(1) << vict_idx;
                offset_line_o  = count;
                mem_addr_o     = {vict_tag, addr_index, count, 2'b00};
                if (last_beat) begin
                    state_next = READ_MEM;
                end
            end

            READ_MEM: begin
                stall_o         = 1'b1;
                mem_req_o       = 1'b1;
                mem_addr_o      = {addr_tag, addr_index, count, 2'b00};
                line_write_en_o = mem_ready_i;
                way_sel_o       = WAYS'(1) << vict_idx;
                offset_line_o   = count;
                if (last_beat) begin
                    set_valid_o = 1'b1;
                    state_next  = IDLE;
                end
            end

            WRITE_AROUND: begin
                stall_o        = 1'b1;
                mem_req_o      = 1'b1;
                mem_write_en_o = 1'b1;
                mem_addr_o     = addr_i & 32'hFFFF_FFFC;
                if (mem_ready_i) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_controller_nway.sv
// Directed bench for cache_controller_nway: allocate instance plus a write-around instance.
module tb_cache_controller_nway;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        en_wa = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  hit_way = '0;
    logic [3:0]  valid = '0;
    logic [3:0]  dirty = '0;
    logic [71:0] tag_line = '0;
    logic [1:0]  victim = '0;
    logic        mem_ready = 1'b0;

    logic        stall, line_we, update_en, set_valid, set_dirty, mem_req, mem_we;
    logic [3:0]  way_sel, offset;
    logic [31:0] mem_addr;

    logic        wa_stall, wa_line_we, wa_update_en, wa_set_valid, wa_set_dirty, wa_mem_req, wa_mem_we;
    logic [3:0]  wa_way_sel, wa_offset;
    logic [31:0] wa_mem_addr;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cache_controller_nway dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .write_en_i(we), .addr_i(addr),
        .hit_way_i(hit_way), .valid_i(valid), .dirty_i(dirty), .tag_line_i(tag_line),
        .victim_i(victim), .stall_o(stall), .way_sel_o(way_sel), .line_write_en_o(line_we),
        .update_en_o(update_en), .set_valid_o(set_valid), .set_dirty_o(set_dirty),
        .offset_line_o(offset), .mem_req_o(mem_req), .mem_write_en_o(mem_we),
        .mem_addr_o(mem_addr), .mem_ready_i(mem_ready)
    );

    cache_controller_nway #(.WRITE_ALLOCATE(1'b0)) dut_wa (
        .clk_i(clk), .rst_i(rst), .en_i(en_wa), .write_en_i(we), .addr_i(addr),
        .hit_way_i(hit_way), .valid_i(valid), .dirty_i(dirty), .tag_line_i(tag_line),
        .victim_i(victim), .stall_o(wa_stall), .way_sel_o(wa_way_sel), .line_write_en_o(wa_line_we),
        .update_en_o(wa_update_en), .set_valid_o(wa_set_valid), .set_dirty_o(wa_set_dirty),
        .offset_line_o(wa_offset), .mem_req_o(wa_mem_req), .mem_write_en_o(wa_mem_we),
        .mem_addr_o(wa_mem_addr), .mem_ready_i(mem_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] beat_addr(input logic [17:0] t, input logic [7:0] idx, input int k);
        addr_fields_t f;
        f.tag      = t;
        f.index    = idx;
        f.word     = 4'(k);
        f.byte_sel = 2'b00;
        return 32'(f);
    endfunction

    initial begin
        addr_fields_t fa;
        int k;

        // Reset, then idle with en low: everything quiet
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_way", 32'(way_sel), 0);
        chk("rst_upd", 32'(update_en), 0);
        chk("rst_off", 32'(offset), 0);
        chk("rst_wa_req", 32'(wa_mem_req), 0);

        // Read hit on way 2
        en = 1'b1; we = 1'b0; hit_way = 4'b0100; addr = 32'h0000_1248;
        #1;
        chk("hit_stall", 32'(stall), 0);
        chk("hit_way", 32'(way_sel), 32'h4);
        chk("hit_upd", 32'(update_en), 1);
        chk("hit_req", 32'(mem_req), 0);
        chk("hit_lwe", 32'(line_we), 0);
        chk("hit_off", 32'(offset), 2);
        // Write hit marks dirty
        we = 1'b1;
        #1;
        chk("whit_lwe", 32'(line_we), 1);
        chk("whit_dirty", 32'(set_dirty), 1);
        tick();

        // Clean read miss, victim 1, memory always ready
        we = 1'b0; hit_way = 4'b0000; victim = 2'd1; valid = 4'b1111; dirty = 4'b0000;
        addr = 32'h0000_1240; mem_ready = 1'b1; tag_line = 72'h0;
        #1;
        chk("cm_stall_idle", 32'(stall), 1);
        chk("cm_req_idle", 32'(mem_req), 0);
        tick();
        victim = 2'd3; en = 1'b0;
        for (k = 0; k < 16; k++) begin
            chk("cm_req", 32'(mem_req), 1);
            chk("cm_mwe", 32'(mem_we), 0);
            chk("cm_addr", mem_addr, 32'h0000_1240 + 32'(4 * k));
            chk("cm_lwe", 32'(line_we), 1);
            chk("cm_way", 32'(way_sel), 32'h2);
            chk("cm_off", 32'(offset), 32'(k));
            chk("cm_sv", 32'(set_valid), (k == 15) ? 32'd1 : 32'd0);
            chk("cm_sd", 32'(set_dirty), 0);
            tick();
        end
        chk("cm_end_stall", 32'(stall), 0);
        chk("cm_end_req", 32'(mem_req), 0);

        // Dirty miss on way 2 (tag 0x2A5), memory ready every third cycle
        en = 1'b1; addr = 32'h0000_C480; victim = 2'd2; valid = 4'b1111; dirty = 4'b0100;
        tag_line = 72'h2A5 << 36; mem_ready = 1'b0;
        fa = split_addr(addr);
        #1;
        chk("dm_stall_idle", 32'(stall), 1);
        tick();
        tag_line = 72'h3FFFF << 36; victim = 2'd0;
        for (int c = 0; c < 48; c++) begin
            mem_ready = (c % 3 == 2);
            #1;
            chk("wb_req", 32'(mem_req), 1);
            chk("wb_mwe", 32'(mem_we), 1);
            chk("wb_addr", mem_addr, beat_addr(18'h2A5, 8'h12, c / 3));
            chk("wb_way", 32'(way_sel), 32'h4);
            chk("wb_off", 32'(offset), 32'(c / 3));
            chk("wb_lwe", 32'(line_we), 0);
            tick();
        end
        en = 1'b0;
        for (int c = 0; c < 48; c++) begin
            mem_ready = (c % 3 == 2);
            #1;
            chk("rf_req", 32'(mem_req), 1);
            chk("rf_mwe", 32'(mem_we), 0);
            chk("rf_addr", mem_addr, beat_addr(fa.tag, fa.index, c / 3));
            chk("rf_way", 32'(way_sel), 32'h4);
            chk("rf_lwe", 32'(line_we), 32'(mem_ready));
            chk("rf_sv", 32'(set_valid), (c == 47) ? 32'd1 : 32'd0);
            tick();
        end
        mem_ready = 1'b0;
        #1;
        chk("rf_end_stall", 32'(stall), 0);
        chk("rf_end_req", 32'(mem_req), 0);

        // Reset on beat 5 of a refill, then a fresh miss restarts at offset 0
        en = 1'b1; addr = 32'h0000_1240; victim = 2'd0; valid = 4'b0000; dirty = 4'b0001;
        mem_ready = 1'b1;
        tick();
        for (k = 0; k < 5; k++) begin
            chk("rr_off", 32'(offset), 32'(k));
            tick();
        end
        chk("rr_off5", 32'(offset), 5);
        chk("rr_sv5", 32'(set_valid), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b0;
        #1;
        chk("rr_req", 32'(mem_req), 0);
        chk("rr_stall", 32'(stall), 0);
        chk("rr_sv", 32'(set_valid), 0);
        en = 1'b1;
        #1;
        chk("rr_remiss", 32'(stall), 1);
        tick();
        chk("rr_restart_off", 32'(offset), 0);
        chk("rr_restart_addr", mem_addr, 32'h0000_1240);
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0;

        // Write-around instance: write miss to a dirty victim goes straight to memory
        en_wa = 1'b1; we = 1'b1; hit_way = 4'b0000; addr = 32'h0000_0F08;
        victim = 2'd1; valid = 4'b1111; dirty = 4'b1111; mem_ready = 1'b0;
        #1;
        chk("wa_stall_idle", 32'(wa_stall), 1);
        tick();
        en_wa = 1'b0;
        #1;
        chk("wa_req", 32'(wa_mem_req), 1);
        chk("wa_mwe", 32'(wa_mem_we), 1);
        chk("wa_addr", wa_mem_addr, 32'h0000_0F08);
        chk("wa_lwe", 32'(wa_line_we), 0);
        chk("wa_stall", 32'(wa_stall), 1);
        tick();
        chk("wa_hold_addr", wa_mem_addr, 32'h0000_0F08);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        #1;
        chk("done_stall", 32'(wa_stall), 0);
        chk("done_req", 32'(wa_mem_req), 0);
        chk("done_lwe", 32'(wa_line_we), 0);
        tick();
        chk("wa_idle_req", 32'(wa_mem_req), 0);
        chk("main_idle_req", 32'(mem_req), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
